// File: rtl/ibex_bist_pkg.sv
// Shared types, register offsets and LFSR/MISR helpers for the ALU idle-time BIST controller.
package ibex_bist_pkg;

  // Subset of the Ibex ALU operator encoding that the BIST sequence exercises.
  typedef enum logic [6:0] {
    ALU_ADD  = 7'd0,
    ALU_SUB  = 7'd1,
    ALU_XOR  = 7'd2,
    ALU_OR   = 7'd3,
    ALU_AND  = 7'd4,
    ALU_SRA  = 7'd8,
    ALU_SRL  = 7'd9,
    ALU_SLL  = 7'd10,
    ALU_SLT  = 7'd43,
    ALU_SLTU = 7'd44
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    INIT,
    RUN,
    CHECK
  } bist_state_e;

  localparam logic [4:0] REG_CTRL      = 5'h00;
  localparam logic [4:0] REG_STATUS    = 5'h04;
  localparam logic [4:0] REG_VEC_CNT   = 5'h08;
  localparam logic [4:0] REG_GOLDEN    = 5'h0C;
  localparam logic [4:0] REG_SIGNATURE = 5'h10;
  localparam logic [4:0] REG_SEED      = 5'h14;

  localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] OPB_MASK  = 32'h5A5A_5A5A;

  localparam int unsigned NUM_OPS = 10;
  typedef logic [3:0] op_idx_t;

  localparam alu_op_e OP_TABLE [NUM_OPS] = '{
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  };

  // Galois shift shared by the vector LFSR (din = 0) and the result MISR.
  function automatic logic [31:0] galois_step(input logic [31:0] s, input logic [31:0] poly,
                                              input logic [31:0] din);
    return ({s[30:0], 1'b0} ^ (s[31] ? poly : 32'h0)) ^ din;
  endfunction

  function automatic logic [31:0] opb_scramble(input logic [31:0] l);
    return {l[15:0], l[31:16]} ^ OPB_MASK;
  endfunction

endpackage

// File: rtl/ibex_bist_apb_regs.sv
// Zero-wait-state APB slave and register file for the ALU BIST controller.
// STATUS done/fail/abort are W1C; a same-cycle hardware set beats the software clear.
module ibex_bist_apb_regs
  import ibex_bist_pkg::*;
#(
  parameter int unsigned VecCntW = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        paddr_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               enable_o,
  output logic               start_o,
  output logic [VecCntW-1:0] vec_cnt_o,
  output logic [31:0]        golden_o,
  output logic [31:0]        seed_o,
  output logic               fail_o,
  input  logic               busy_set_i,
  input  logic               busy_clr_i,
  input  logic               done_set_i,
  input  logic               fail_set_i,
  input  logic               abort_set_i,
  input  logic               status_clr_i,
  input  logic               sig_wr_i,
  input  logic [31:0]        sig_i
);

  logic               enable_q, enable_d, start_q, start_d;
  logic [VecCntW-1:0] vec_cnt_q, vec_cnt_d;
  logic [31:0]        golden_q, golden_d, seed_q, seed_d, sig_q, sig_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d, abort_q, abort_d;
  logic               wr_en;
  logic [2:0]         widx;
  logic [31:0]        rdata;
  logic               unused_paddr;

  assign pready_o     = psel_i & penable_i;
  assign wr_en        = pready_o & pwrite_i;
  assign widx         = paddr_i[4:2];
  assign unused_paddr = ^{paddr_i[31:5], paddr_i[1:0]};

  always_comb begin
    enable_d  = enable_q;
    vec_cnt_d = vec_cnt_q;
    golden_d  = golden_q;
    seed_d    = seed_q;
    sig_d     = sig_wr_i ? sig_i : sig_q;
    // start is a one-cycle pulse; requests arriving while a run is in flight are dropped
    start_d   = wr_en && (widx == REG_CTRL[4:2]) && pwdata_i[1] && !busy_q;
    busy_d    = busy_set_i ? 1'b1 : (busy_clr_i ? 1'b0 : busy_q);
    done_d    = done_q & ~status_clr_i;
    fail_d    = fail_q;
    abort_d   = abort_q & ~status_clr_i;
    if (wr_en) begin
      case (widx)
        REG_CTRL[4:2]:    enable_d  = pwdata_i[0];
        REG_STATUS[4:2]: begin
          done_d  = done_d  & ~pwdata_i[1];
          fail_d  = fail_d  & ~pwdata_i[2];
          abort_d = abort_d & ~pwdata_i[3];
        end
        REG_VEC_CNT[4:2]: vec_cnt_d = pwdata_i[VecCntW-1:0];
        REG_GOLDEN[4:2]:  golden_d  = pwdata_i;
        REG_SEED[4:2]:    seed_d    = (pwdata_i == 32'h0) ? 32'h1 : pwdata_i;
        default: ;
      endcase
    end
    // fail is sticky across new starts so the level irq survives until software clears it
    done_d  = done_d  | done_set_i;
    fail_d  = fail_d  | fail_set_i;
    abort_d = abort_d | abort_set_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q  <= 1'b0;
      start_q   <= 1'b0;
      vec_cnt_q <= '0;
      golden_q  <= '0;
      seed_q    <= 32'h1;
      sig_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      start_q   <= start_d;
      vec_cnt_q <= vec_cnt_d;
      golden_q  <= golden_d;
      seed_q    <= seed_d;
      sig_q     <= sig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (widx)
      REG_CTRL[4:2]:      rdata = {31'b0, enable_q};
      REG_STATUS[4:2]:    rdata = {28'b0, abort_q, fail_q, done_q, busy_q};
      REG_VEC_CNT[4:2]:   rdata = 32'(vec_cnt_q);
      REG_GOLDEN[4:2]:    rdata = golden_q;
      REG_SIGNATURE[4:2]: rdata = sig_q;
      REG_SEED[4:2]:      rdata = seed_q;
      default:            rdata = '0;
    endcase
  end

  assign prdata_o  = pready_o ? rdata : 32'h0;
  assign enable_o  = enable_q;
  assign start_o   = start_q;
  assign vec_cnt_o = vec_cnt_q;
  assign golden_o  = golden_q;
  assign seed_o    = seed_q;
  assign fail_o    = fail_q;

endmodule

// File: rtl/ibex_alu_bist_ctrl.sv
// Idle-time ALU self-test: LFSR vectors through a fixed operator table, MISR-compacted, checked vs GOLDEN.
// Optional IBEX_BIST_FAULT_INJ_EN adds sim_fault_inject_i, which flips result bit 0 during RUN.
module ibex_alu_bist_ctrl
  import ibex_bist_pkg::*;
#(
  parameter int unsigned VecCntW  = 16,
  parameter logic [31:0] MisrPoly = 32'h8020_0003
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_sleep_i,
  input  logic [31:0] alu_result_i,
`ifdef IBEX_BIST_FAULT_INJ_EN
  input  logic        sim_fault_inject_i,
`endif
  output logic        bist_active_o,
  output logic [6:0]  bist_operator_o,
  output logic [31:0] bist_operand_a_o,
  output logic [31:0] bist_operand_b_o,
  output logic        bist_error_irq_o,
  input  logic [31:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o
);

  logic               enable, start, fail;
  logic [VecCntW-1:0] vec_cnt;
  logic [31:0]        golden, seed;
  logic               busy_set, busy_clr, done_set, fail_set, abort_set, status_clr, sig_wr;

  bist_state_e        state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d, misr_q, misr_d;
  logic [VecCntW-1:0] cnt_q, cnt_d;
  op_idx_t            idx_q, idx_d;
  logic               active_q, active_d;
  alu_op_e            operator_q, operator_d;
  logic [31:0]        opa_q, opa_d, opb_q, opb_d;
  logic [31:0]        alu_res;

`ifdef IBEX_BIST_FAULT_INJ_EN
  assign alu_res = alu_result_i ^ {31'b0, sim_fault_inject_i & (state_q == RUN)};
`else
  assign alu_res = alu_result_i;
`endif

  ibex_bist_apb_regs #(.VecCntW(VecCntW)) u_regs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .paddr_i     (paddr_i),
    .psel_i      (psel_i),
    .penable_i   (penable_i),
    .pwrite_i    (pwrite_i),
    .pwdata_i    (pwdata_i),
    .prdata_o    (prdata_o),
    .pready_o    (pready_o),
    .enable_o    (enable),
    .start_o     (start),
    .vec_cnt_o   (vec_cnt),
    .golden_o    (golden),
    .seed_o      (seed),
    .fail_o      (fail),
    .busy_set_i  (busy_set),
    .busy_clr_i  (busy_clr),
    .done_set_i  (done_set),
    .fail_set_i  (fail_set),
    .abort_set_i (abort_set),
    .status_clr_i(status_clr),
    .sig_wr_i    (sig_wr),
    .sig_i       (misr_q)
  );

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    misr_d     = misr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    busy_set   = 1'b0;
    busy_clr   = 1'b0;
    done_set   = 1'b0;
    fail_set   = 1'b0;
    abort_set  = 1'b0;
    status_clr = 1'b0;
    sig_wr     = 1'b0;
    case (state_q)
      IDLE: if (start && enable) begin
        status_clr = 1'b1;
        busy_set   = 1'b1;
        state_d    = ARM;
      end
      ARM: begin
        if (!enable) begin
          busy_clr = 1'b1;
          state_d  = IDLE;
        end else if (core_sleep_i) begin
          state_d = INIT;
        end
      end
      INIT, RUN: begin
        if (!core_sleep_i) begin
          // core woke: release the ALU immediately, keep the previous signature
          abort_set = 1'b1;
          busy_clr  = 1'b1;
          state_d   = IDLE;
        end else if (state_q == INIT) begin
          lfsr_d  = seed;
          misr_d  = MISR_INIT;
          cnt_d   = vec_cnt;
          idx_d   = '0;
          state_d = (vec_cnt == '0) ? CHECK : RUN;
        end else begin
          misr_d = galois_step(misr_q, MisrPoly, alu_res);
          lfsr_d = galois_step(lfsr_q, MisrPoly, 32'h0);
          idx_d  = (idx_q == op_idx_t'(NUM_OPS - 1)) ? '0 : idx_q + op_idx_t'(1);
          cnt_d  = cnt_q - VecCntW'(1);
          if (cnt_q == VecCntW'(1)) state_d = CHECK;
        end
      end
      CHECK: begin
        sig_wr   = 1'b1;
        done_set = 1'b1;
        fail_set = (misr_q != golden);
        busy_clr = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the values the next cycle will hold.
    active_d   = (state_d == RUN);
    operator_d = active_d ? OP_TABLE[idx_d] : ALU_ADD;
    opa_d      = active_d ? lfsr_d : 32'h0;
    opb_d      = active_d ? opb_scramble(lfsr_d) : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      misr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      active_q   <= 1'b0;
      operator_q <= ALU_ADD;
      opa_q      <= '0;
      opb_q      <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      misr_q     <= misr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      operator_q <= operator_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
    end
  end

  assign bist_active_o    = active_q;
  assign bist_operator_o  = operator_q;
  assign bist_operand_a_o = opa_q;
  assign bist_operand_b_o = opb_q;
  assign bist_error_irq_o = fail;

endmodule

// File: tb/tb_ibex_alu_bist_ctrl.sv
// Bench for ibex_alu_bist_ctrl: reference ALU feeds results back; a vector scoreboard checks every RUN cycle.
module tb_ibex_alu_bist_ctrl;
  import ibex_bist_pkg::*;

  localparam logic [31:0] POLY   = 32'h8020_0003;
  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_VCNT = 32'h08;
  localparam logic [31:0] A_GOLD = 32'h0C, A_SIG  = 32'h10, A_SEED = 32'h14, A_UNMAP = 32'h18;

  logic        clk_i = 1'b0, rst_i = 1'b1, core_sleep_i = 1'b0;
  logic [31:0] alu_result_i;
  logic        bist_active_o, bist_error_irq_o, pready_o;
  logic [6:0]  bist_operator_o;
  logic [31:0] bist_operand_a_o, bist_operand_b_o, prdata_o;
  logic [31:0] paddr_i = '0, pwdata_i = '0;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
`ifdef IBEX_BIST_FAULT_INJ_EN
  logic        sim_fault_inject_i = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t    exp_q[$];
  vec_t    mv;
  int      n_checks = 0, n_fail = 0, run_cycles = 0;
  bit      mon_en = 1'b0;
  alu_op_e tb_ops [10] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
                           ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};

  always #5 clk_i = ~clk_i;

  ibex_alu_bist_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .core_sleep_i    (core_sleep_i),
    .alu_result_i    (alu_result_i),
`ifdef IBEX_BIST_FAULT_INJ_EN
    .sim_fault_inject_i(sim_fault_inject_i),
`endif
    .bist_active_o   (bist_active_o),
    .bist_operator_o (bist_operator_o),
    .bist_operand_a_o(bist_operand_a_o),
    .bist_operand_b_o(bist_operand_b_o),
    .bist_error_irq_o(bist_error_irq_o),
    .paddr_i         (paddr_i),
    .psel_i          (psel_i),
    .penable_i       (penable_i),
    .pwrite_i        (pwrite_i),
    .pwdata_i        (pwdata_i),
    .prdata_o        (prdata_o),
    .pready_o        (pready_o)
  );

  function automatic logic [31:0] alu_ref(input logic [6:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (alu_op_e'(op))
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

  assign alu_result_i = alu_ref(bist_operator_o, bist_operand_a_o, bist_operand_b_o);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference run: pushes every expected vector and returns the expected signature.
  task automatic model_run(input logic [31:0] seed, input int n, output logic [31:0] sig);
    logic [31:0] l, m, r;
    int          k;
    vec_t        v;
    l = seed;
    m = 32'hFFFF_FFFF;
    k = 0;
    for (int i = 0; i < n; i++) begin
      v.op = tb_ops[k];
      v.a  = l;
      v.b  = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A;
      exp_q.push_back(v);
      r = alu_ref(v.op, v.a, v.b);
      m = ({m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0)) ^ r;
      l = {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
      k = (k == 9) ? 0 : k + 1;
    end
    sig = m;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && mon_en) begin
      if (bist_active_o) begin
        run_cycles++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_vec", 32'(bist_active_o), 32'h0);
        end else begin
          mv = exp_q.pop_front();
          check_val("vec_op", 32'(bist_operator_o), 32'(mv.op));
          check_val("vec_a", bist_operand_a_o, mv.a);
          check_val("vec_b", bist_operand_b_o, mv.b);
        end
      end else begin
        check_val("idle_outs", {25'b0, bist_operator_o} | bist_operand_a_o | bist_operand_b_o, 32'h0);
      end
    end
  end

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = addr; pwdata_i = data;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = addr;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    #3 data = prdata_o;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    check_val(tag, d, exp);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int          polls;
    polls = 0;
    st    = 32'h1;
    while (st[0] && polls < 400) begin
      apb_read(A_STAT, st);
      polls++;
    end
    if (st[0]) check_val("busy_timeout", {31'b0, st[0]}, 32'h0);
  endtask

  task automatic wait_runs(input int n);
    int t;
    t = 0;
    while (run_cycles < n && t < 1000) begin
      @(negedge clk_i); #1;
      t++;
    end
    if (run_cycles < n) check_val("run_timeout", 32'(run_cycles), 32'(n));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sig, sig_prev, dummy;
    int          base;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_active", 32'(bist_active_o), 32'h0);
    check_val("rst_outs", {25'b0, bist_operator_o} | bist_operand_a_o | bist_operand_b_o, 32'h0);
    check_val("rst_irq", 32'(bist_error_irq_o), 32'h0);
    check_val("rst_pready", 32'(pready_o), 32'h0);
    check_val("rst_prdata", prdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;
    read_check("rst_ctrl", A_CTRL, 32'h0);
    read_check("rst_status", A_STAT, 32'h0);
    read_check("rst_veccnt", A_VCNT, 32'h0);
    read_check("rst_golden", A_GOLD, 32'h0);
    read_check("rst_sig", A_SIG, 32'h0);
    read_check("rst_seed", A_SEED, 32'h1);

    // Single vector, matching golden.
    core_sleep_i = 1'b1;
    apb_write(A_SEED, 32'h1);
    apb_write(A_VCNT, 32'h1);
    apb_write(A_GOLD, 32'h2584_A5A6);
    model_run(32'h1, 1, dummy);
    apb_write(A_CTRL, 32'h3);
    wait_idle();
    read_check("t1_sig", A_SIG, 32'h2584_A5A6);
    read_check("t1_status", A_STAT, 32'h2);
    check_val("t1_irq", 32'(bist_error_irq_o), 32'h0);
    check_val("t1_drained", 32'(exp_q.size()), 32'h0);

    // Same run with a wrong golden.
    apb_write(A_GOLD, 32'h0);
    model_run(32'h1, 1, dummy);
    apb_write(A_CTRL, 32'h3);
    wait_idle();
    read_check("t2_status", A_STAT, 32'h6);
    check_val("t2_irq", 32'(bist_error_irq_o), 32'h1);

    // Start while awake: ARM holds, irq stays up, clearing enable returns to IDLE.
    core_sleep_i = 1'b0;
    apb_write(A_CTRL, 32'h3);
    repeat (6) @(negedge clk_i);
    read_check("arm_status", A_STAT, 32'h5);
    check_val("arm_irq_sticky", 32'(bist_error_irq_o), 32'h1);
    apb_write(A_CTRL, 32'h0);
    read_check("arm_exit_status", A_STAT, 32'h4);
    apb_write(A_STAT, 32'h4);
    check_val("w1c_irq", 32'(bist_error_irq_o), 32'h0);
    read_check("w1c_status", A_STAT, 32'h0);

    // Zero vectors: signature is the MISR seed.
    core_sleep_i = 1'b1;
    base = run_cycles;
    apb_write(A_VCNT, 32'h0);
    apb_write(A_GOLD, 32'hFFFF_FFFF);
    apb_write(A_CTRL, 32'h3);
    wait_idle();
    read_check("t3_sig", A_SIG, 32'hFFFF_FFFF);
    read_check("t3_status", A_STAT, 32'h2);
    check_val("t3_no_run", 32'(run_cycles - base), 32'h0);

    // Wait in ARM, then sleep begins a 13-vector run that wraps the operator table.
    core_sleep_i = 1'b0;
    apb_write(A_SEED, 32'h1234_5678);
    apb_write(A_VCNT, 32'd13);
    model_run(32'h1234_5678, 13, sig);
    apb_write(A_GOLD, sig);
    apb_write(A_CTRL, 32'h3);
    repeat (4) @(negedge clk_i);
    read_check("t4_arm_busy", A_STAT, 32'h1);
    core_sleep_i = 1'b1;
    wait_idle();
    read_check("t4_sig", A_SIG, sig);
    read_check("t4_status", A_STAT, 32'h2);
    check_val("t4_drained", 32'(exp_q.size()), 32'h0);
    sig_prev = sig;

    // Abort after 20 RUN cycles of a 100-vector run.
    apb_write(A_SEED, 32'h0000_ACE1);
    apb_write(A_VCNT, 32'd100);
    model_run(32'h0000_ACE1, 100, dummy);
    base = run_cycles;
    apb_write(A_CTRL, 32'h3);
    wait_runs(base + 20);
    core_sleep_i = 1'b0;
    check_val("abort_active_before", 32'(bist_active_o), 32'h1);
    @(negedge clk_i); #1;
    check_val("abort_active_after", 32'(bist_active_o), 32'h0);
    check_val("abort_run_count", 32'(run_cycles - base), 32'd20);
    exp_q.delete();
    read_check("abort_status", A_STAT, 32'h8);
    read_check("abort_sig_kept", A_SIG, sig_prev);

    // Register corner cases.
    apb_write(A_SEED, 32'h0);
    read_check("seed_zero", A_SEED, 32'h1);
    apb_write(A_VCNT, 32'hFFFF_FFFF);
    read_check("veccnt_width", A_VCNT, 32'h0000_FFFF);
    apb_write(A_UNMAP, 32'hDEAD_BEEF);
    read_check("unmapped", A_UNMAP, 32'h0);
    apb_write(A_SIG, 32'h0);
    read_check("sig_ro", A_SIG, sig_prev);
    apb_write(A_CTRL, 32'h2);
    read_check("ctrl_start_reads0", A_CTRL, 32'h0);
    read_check("start_needs_enable", A_STAT, 32'h8);

    // Reset in the middle of a run.
    core_sleep_i = 1'b1;
    apb_write(A_SEED, 32'h3);
    apb_write(A_VCNT, 32'd50);
    model_run(32'h3, 50, dummy);
    base = run_cycles;
    apb_write(A_CTRL, 32'h3);
    wait_runs(base + 5);
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    check_val("midrst_active", 32'(bist_active_o), 32'h0);
    check_val("midrst_outs", {25'b0, bist_operator_o} | bist_operand_a_o | bist_operand_b_o, 32'h0);
    check_val("midrst_irq", 32'(bist_error_irq_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    read_check("midrst_status", A_STAT, 32'h0);
    read_check("midrst_seed", A_SEED, 32'h1);
    read_check("midrst_ctrl", A_CTRL, 32'h0);
    read_check("midrst_sig", A_SIG, 32'h0);

`ifdef IBEX_BIST_FAULT_INJ_EN
    apb_write(A_VCNT, 32'h1);
    apb_write(A_GOLD, 32'h2584_A5A6);
    model_run(32'h1, 1, dummy);
    sim_fault_inject_i = 1'b1;
    apb_write(A_CTRL, 32'h3);
    wait_idle();
    sim_fault_inject_i = 1'b0;
    read_check("fi_sig", A_SIG, 32'h2584_A5A7);
    read_check("fi_status", A_STAT, 32'h6);
    check_val("fi_irq", 32'(bist_error_irq_o), 32'h1);
`endif

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
